reset_controller: RTL and testbench

- Central reset scheduler for the SoC clock/reset block.
- Merges power-on, software, watchdog and debug reset requests into one reset event.
- Holds every downstream domain in reset for a programmable time, then releases NSTAGE reset outputs in fixed order (stage 0 first) with a programmable gap between releases.
- Each rst_out bit feeds the per-domain reset synchronizer of its target clock domain. The block also records the reset cause for software.

---
 rtl/reset_controller_if.sv | 24 ++
 rtl/reset_controller.sv | 121 ++++++++++++
 tb/tb_reset_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/reset_controller_if.sv
// Request/status bundle between the reset controller and the SoC clock/reset block.
// The slave modport is the controller side.
interface reset_controller_if #(
    parameter int NSTAGE = 3
);
    logic              sw_req;
    logic              wdt_req;
    logic              dbg_req;
    logic              cause_clr;
    logic [NSTAGE-1:0] rst_out;
    logic              busy;
    logic              done;
    logic [3:0]        rst_cause;

    modport master (
        output sw_req, wdt_req, dbg_req, cause_clr,
        input  rst_out, busy, done, rst_cause
    );

    modport slave (
        input  sw_req, wdt_req, dbg_req, cause_clr,
        output rst_out, busy, done, rst_cause
    );
endinterface

// File: rtl/reset_controller.sv
// Central reset scheduler: merges POR/sw/wdt/dbg requests, holds all domains in reset,
// then releases NSTAGE outputs in order with a fixed gap, and records the reset cause.
module reset_controller #(
    parameter int NSTAGE   = 3,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 8,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    reset_controller_if.slave bus
);
    localparam int IDX_W = $clog2(NSTAGE + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NSTAGE - 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_GAP  = 2'd1,
        S_IDLE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NSTAGE-1:0] rst_out_q, rst_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        cause_q, cause_d;

    logic       any_req;
    logic       release_now;
    logic [3:0] req_bits;

    assign any_req  = bus.sw_req | bus.wdt_req | bus.dbg_req;
    assign req_bits = {bus.dbg_req, bus.wdt_req, bus.sw_req, 1'b0};
    assign release_now = ((state_q == S_HOLD) && (cnt_q == HOLD_LAST)) ||
                         ((state_q == S_GAP)  && (cnt_q == GAP_LAST));

    // State register; outputs are registered alongside so rst_out only moves on a clk edge.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            cause_q   <= 4'b0001;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state logic: a request restarts the sequence from any state.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (any_req) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        idx_d   = IDX_W'(1);
                        state_d = (NSTAGE == 1) ? S_IDLE : S_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_IDLE: ;
                default: state_d = S_HOLD;
            endcase
        end
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        rst_out_d = rst_out_q;
        cause_d   = cause_q;
        done_d    = 1'b0;
        if (any_req) begin
            rst_out_d = '1;
            cause_d   = (state_q == S_IDLE) ? req_bits : (cause_q | req_bits);
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (release_now && (idx_q == IDX_W'(k))) rst_out_d[k] = 1'b0;
            end
            done_d = release_now && (idx_q == IDX_LAST);
            if ((state_q == S_IDLE) && bus.cause_clr) cause_d = 4'b0000;
        end
        busy_d = |rst_out_d;
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_reset_controller.sv
// Bench for reset_controller: a default instance and an NSTAGE=1/HOLD_CYC=1 instance share stimulus;
// expected outputs come from the release-edge timing formula and are queued for a negedge monitor.
module tb_reset_controller;
    typedef struct packed {
        logic [7:0] rst_out;
        logic       busy;
        logic       done;
        logic [3:0] cause;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw = 1'b0, wdt = 1'b0, dbg = 1'b0, clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    int   e[2];
    logic [3:0] cause_m[2];
    exp_t got_a, got_b, want_a, want_b;

    reset_controller_if #(.NSTAGE(3)) bus_a ();
    reset_controller_if #(.NSTAGE(1)) bus_b ();

    assign bus_a.sw_req = sw;  assign bus_a.wdt_req = wdt;
    assign bus_a.dbg_req = dbg; assign bus_a.cause_clr = clr;
    assign bus_b.sw_req = sw;  assign bus_b.wdt_req = wdt;
    assign bus_b.dbg_req = dbg; assign bus_b.cause_clr = clr;

    reset_controller #(.NSTAGE(3), .HOLD_CYC(16), .GAP_CYC(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    reset_controller #(.NSTAGE(1), .HOLD_CYC(1), .GAP_CYC(8), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    always #5 clk = ~clk;

    function automatic int hold_of(int d); return (d == 0) ? 16 : 1; endfunction
    function automatic int gap_of(int d);  return 8; endfunction
    function automatic int ns_of(int d);   return (d == 0) ? 3 : 1; endfunction
    function automatic int last_of(int d);
        return hold_of(d) + (ns_of(d) - 1) * gap_of(d);
    endfunction

    // Bit k is low once HOLD + k*GAP edges have passed since the sequence started.
    function automatic exp_t expect_of(int d);
        exp_t x;
        x = '0;
        for (int k = 0; k < ns_of(d); k++)
            x.rst_out[k] = (e[d] < hold_of(d) + k * gap_of(d));
        x.busy  = |x.rst_out;
        x.done  = rst_n && (e[d] == last_of(d));
        x.cause = cause_m[d];
        return x;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                e[d] = 0;
                cause_m[d] = 4'b0001;
            end else if (sw | wdt | dbg) begin
                if (e[d] >= last_of(d)) cause_m[d] = {dbg, wdt, sw, 1'b0};
                else                    cause_m[d] = cause_m[d] | {dbg, wdt, sw, 1'b0};
                e[d] = 0;
            end else begin
                if ((e[d] >= last_of(d)) && clr) cause_m[d] = 4'b0000;
                if (e[d] < 1000) e[d] = e[d] + 1;
            end
        end
    endtask

    // One clock: account for the edge, optionally apply async reset, queue expectations, drive next inputs.
    task automatic tick(input logic r, input logic s, input logic w, input logic dg, input logic c);
        @(posedge clk);
        model_edge();
        #1;
        rst_n = r;
        if (!r) begin
            for (int d = 0; d < 2; d++) begin
                e[d] = 0;
                cause_m[d] = 4'b0001;
            end
        end
        q_a.push_back(expect_of(0));
        q_b.push_back(expect_of(1));
        sw = s; wdt = w; dbg = dg; clr = c;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s @%0t: got rst_out=%b busy=%b done=%b cause=%b, want rst_out=%b busy=%b done=%b cause=%b",
                     name, $time, got.rst_out, got.busy, got.done, got.cause,
                     want.rst_out, want.busy, want.done, want.cause);
        end
    endtask

    // Monitor: compares whatever the DUTs present against the oldest queued expectation.
    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            want_a = q_a.pop_front();
            got_a  = {8'(bus_a.rst_out), bus_a.busy, bus_a.done, bus_a.rst_cause};
            check("dut_a", got_a, want_a);
        end
        if (q_b.size() > 0) begin
            want_b = q_b.pop_front();
            got_b  = {8'(bus_b.rst_out), bus_b.busy, bus_b.done, bus_b.rst_cause};
            check("dut_b", got_b, want_b);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            e[d] = 0;
            cause_m[d] = 4'b0001;
        end

        // Power-on reset, then release with no requests.
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(40);

        // Single-cycle watchdog request from IDLE.
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(40);

        // Fresh POR, then software request mid-release.
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(25);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run(40);

        // Debug request held for 50 cycles.
        repeat (50) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run(40);

        // cause_clr alone in IDLE, together with sw_req, then during HOLD.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run(2);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run(5);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run(40);

        // Async reset in the middle of a GAP phase.
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(20);
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(40);

        for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clk);
        if (q_a.size() > 0 || q_b.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d/%0d expectations left unchecked, want 0", q_a.size(), q_b.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
